// File: rtl/usermem.sv
// Byte-addressed user memory: RAM below IO_BASE, timer/interrupt/output registers above it,
// all reached through one shared tri-state data bus.
module usermem #(
    parameter logic [7:0] IO_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] usermem_address,
    inout  wire  [7:0] usermem_data,
    input  logic       rw,
    output logic       interrupt,
    output logic [7:0] io_out
);

    localparam int RAM_DEPTH = int'(IO_BASE);

    localparam logic [7:0] OFS_OUT    = 8'd0;
    localparam logic [7:0] OFS_RELOAD = 8'd1;
    localparam logic [7:0] OFS_COUNT  = 8'd2;
    localparam logic [7:0] OFS_CTRL   = 8'd3;
    localparam logic [7:0] OFS_STATUS = 8'd4;

    logic [7:0] mem [RAM_DEPTH];

    logic [7:0] out_reg;
    logic [7:0] reload_reg;
    logic [7:0] count_reg;
    logic       timer_en;
    logic       irq_en;
    logic       pending;

    logic       is_ram;
    logic [7:0] offset;
    logic       wr_en;
    logic [7:0] wdata;
    logic       wr_out;
    logic       wr_reload;
    logic       wr_ctrl;
    logic       wr_status;
    logic       expire;
    logic [7:0] rdata;

    assign is_ram    = usermem_address < IO_BASE;
    assign offset    = usermem_address - IO_BASE;
    assign wr_en     = !rw && !reset;
    assign wdata     = usermem_data;
    assign wr_out    = wr_en && !is_ram && (offset == OFS_OUT);
    assign wr_reload = wr_en && !is_ram && (offset == OFS_RELOAD);
    assign wr_ctrl   = wr_en && !is_ram && (offset == OFS_CTRL);
    assign wr_status = wr_en && !is_ram && (offset == OFS_STATUS);

    // A RELOAD write in the same cycle takes precedence and suppresses the expiry.
    assign expire = timer_en && (count_reg == 8'd0) && !wr_reload;

    // NOTE: the RAM has no reset branch on purpose; contents survive reset and only
    // the write enable is gated, which also lets it map onto plain memory macros.
    always_ff @(posedge clk) begin
        if (wr_en && is_ram) begin
            mem[usermem_address] <= wdata;
        end
    end

    // NOTE: sequential state always uses non-blocking assignment so every register
    // samples pre-edge values, e.g. the timer sees the old timer_en on a CTRL write.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg    <= 8'h00;
            reload_reg <= 8'h00;
            count_reg  <= 8'h00;
            timer_en   <= 1'b0;
            irq_en     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (wr_out) begin
                out_reg <= wdata;
            end
            if (wr_reload) begin
                reload_reg <= wdata;
            end
            if (wr_ctrl) begin
                timer_en <= wdata[0];
                irq_en   <= wdata[1];
            end

            if (wr_reload) begin
                count_reg <= wdata;
            end else if (timer_en) begin
                count_reg <= (count_reg == 8'd0) ? reload_reg : count_reg - 8'd1;
            end

            if (expire) begin
                pending <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                pending <= 1'b0;
            end
        end
    end

    // NOTE: rdata is given a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = 8'h00;
        if (is_ram) begin
            rdata = mem[usermem_address];
        end else begin
            case (offset)
                OFS_OUT:    rdata = out_reg;
                OFS_RELOAD: rdata = reload_reg;
                OFS_COUNT:  rdata = count_reg;
                OFS_CTRL:   rdata = {6'b0, irq_en, timer_en};
                OFS_STATUS: rdata = {7'b0, pending};
                default:    rdata = 8'h00;
            endcase
        end
    end

    assign usermem_data = (rw && !reset) ? rdata : 8'hzz;
    assign interrupt    = pending && irq_en;
    assign io_out       = out_reg;

endmodule

// File: tb/tb_usermem.sv
// Self-checking bench for usermem: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the memory and timer.
module tb_usermem;

    localparam logic [7:0] IO_BASE = 8'hF0;
    localparam logic [7:0] A_OUT    = IO_BASE;
    localparam logic [7:0] A_RELOAD = IO_BASE + 8'd1;
    localparam logic [7:0] A_COUNT  = IO_BASE + 8'd2;
    localparam logic [7:0] A_CTRL   = IO_BASE + 8'd3;
    localparam logic [7:0] A_STATUS = IO_BASE + 8'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] usermem_address = 8'h00;
    logic       rw = 1'b1;
    logic       interrupt;
    logic [7:0] io_out;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_drive = 8'h00;
    wire  [7:0] bus;

    int n_vec = 0;
    int n_err = 0;

    assign bus = tb_oe ? tb_drive : 8'hzz;

    always #5 clk = ~clk;

    usermem #(.IO_BASE(IO_BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .usermem_address (usermem_address),
        .usermem_data    (bus),
        .rw              (rw),
        .interrupt       (interrupt),
        .io_out          (io_out)
    );

    // Behavioural model state
    logic [7:0] m_ram [256];
    logic [7:0] m_out, m_reload, m_count;
    logic       m_ten, m_ien, m_pending;

    function automatic void model_step(input logic rst, input logic wr,
                                       input logic [7:0] a, input logic [7:0] d);
        logic fires;
        if (rst) begin
            m_out = 0; m_reload = 0; m_count = 0;
            m_ten = 0; m_ien = 0; m_pending = 0;
            return;
        end
        fires = m_ten && (m_count == 0) && !(wr && a == A_RELOAD);
        if (wr && a == A_RELOAD)  m_count = d;
        else if (m_ten)           m_count = (m_count == 0) ? m_reload : m_count - 8'd1;
        if (fires)                                   m_pending = 1'b1;
        else if (wr && a == A_STATUS && d[0])        m_pending = 1'b0;
        if (wr) begin
            if (a < IO_BASE)       m_ram[a] = d;
            else if (a == A_OUT)    m_out = d;
            else if (a == A_RELOAD) m_reload = d;
            else if (a == A_CTRL)   begin m_ten = d[0]; m_ien = d[1]; end
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a < IO_BASE)        return m_ram[a];
        if (a == A_OUT)         return m_out;
        if (a == A_RELOAD)      return m_reload;
        if (a == A_COUNT)       return m_count;
        if (a == A_CTRL)        return {6'b0, m_ien, m_ten};
        if (a == A_STATUS)      return {7'b0, m_pending};
        return 8'h00;
    endfunction

    // One bus cycle starting and ending at a falling edge.
    task automatic cyc(input logic wr, input logic [7:0] a, input logic [7:0] d);
        rw = ~wr; tb_oe = wr; usermem_address = a; tb_drive = d;
        @(posedge clk);
        model_step(reset, wr, a, d);
        @(negedge clk);
    endtask

    task automatic setup_read(input logic [7:0] a);
        rw = 1'b1; tb_oe = 1'b0; usermem_address = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0, 8'h00, 8'h00);
        cyc(0, 8'h00, 8'h00);
        reset = 1'b0;
        n_vec++;
        if (io_out !== 8'h00) begin n_err++; $display("FAIL reset_io_out: got %h want 00", io_out); end
        n_vec++;
        if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", interrupt); end
        for (int i = 0; i < 5; i++) begin
            setup_read(8'(IO_BASE + 8'(i)));
            n_vec++;
            if (bus !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", i, bus); end
        end
    endtask

    task automatic test_ram();
        cyc(1, 8'h10, 8'hA5);
        cyc(1, 8'h11, 8'h3C);
        // Release check on a write cycle: the bench is not driving yet, so a
        // released bus reads Z (or 0 in a 2-state simulator), never RAM[0x10].
        rw = 1'b0; tb_oe = 1'b0; usermem_address = 8'h10;
        #1;
        n_vec++;
        if (bus !== 8'hzz && bus !== 8'h00) begin n_err++; $display("FAIL ram_wr_release: got %h want zz", bus); end
        cyc(1, 8'h10, 8'hA5);
        setup_read(8'h10);
        n_vec++;
        if (bus !== 8'hA5) begin n_err++; $display("FAIL ram_rd_10: got %h want a5", bus); end
        setup_read(8'h11);
        n_vec++;
        if (bus !== 8'h3C) begin n_err++; $display("FAIL ram_rd_11: got %h want 3c", bus); end
    endtask

    task automatic test_io_regs();
        cyc(1, A_OUT, 8'h5A);
        n_vec++;
        if (io_out !== 8'h5A) begin n_err++; $display("FAIL out_reg: got %h want 5a", io_out); end
        setup_read(8'(IO_BASE + 8'd7));
        n_vec++;
        if (bus !== 8'h00) begin n_err++; $display("FAIL hole_read: got %h want 00", bus); end
        cyc(1, A_COUNT, 8'h99);
        setup_read(A_COUNT);
        n_vec++;
        if (bus !== 8'h00) begin n_err++; $display("FAIL count_ro: got %h want 00", bus); end
        cyc(1, 8'hFF, 8'h77);
        setup_read(8'hFF);
        n_vec++;
        if (bus !== 8'h00) begin n_err++; $display("FAIL hole_ff: got %h want 00", bus); end
    endtask

    task automatic test_timer();
        cyc(1, A_RELOAD, 8'd3);
        cyc(1, A_CTRL, 8'h03);
        for (int i = 0; i < 4; i++) begin
            setup_read(A_COUNT);
            n_vec++;
            if (bus !== 8'(3 - i)) begin n_err++; $display("FAIL count_seq%0d: got %h want %h", i, bus, 8'(3 - i)); end
            n_vec++;
            if (interrupt !== 1'b0) begin n_err++; $display("FAIL early_irq%0d: got %b want 0", i, interrupt); end
            cyc(0, A_COUNT, 8'h00);
        end
        n_vec++;
        if (interrupt !== 1'b1) begin n_err++; $display("FAIL first_expiry: got %b want 1", interrupt); end
        setup_read(A_COUNT);
        n_vec++;
        if (bus !== 8'd3) begin n_err++; $display("FAIL reload_after_exp: got %h want 03", bus); end
        cyc(1, A_STATUS, 8'h01);
        n_vec++;
        if (interrupt !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %b want 0", interrupt); end
        for (int k = 2; k <= 4; k++) begin
            cyc(0, A_COUNT, 8'h00);
            n_vec++;
            if (interrupt !== (k == 4)) begin n_err++; $display("FAIL period_edge%0d: got %b want %b", k, interrupt, (k == 4)); end
        end
    endtask

    task automatic test_status_race();
        int guard;
        guard = 0;
        while (m_count != 0 && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        n_vec++;
        if (guard >= 300) begin n_err++; $display("FAIL race_timeout: got %0d want <300", guard); end
        cyc(1, A_STATUS, 8'h01);
        n_vec++;
        if (interrupt !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b want 1", interrupt); end
        cyc(1, A_STATUS, 8'h01);
        setup_read(A_STATUS);
        n_vec++;
        if (bus !== 8'h00 || interrupt !== 1'b0) begin n_err++; $display("FAIL clear_nonexp: got %h/%b want 00/0", bus, interrupt); end
        guard = 0;
        while (!m_pending && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        cyc(1, A_STATUS, 8'h00);
        setup_read(A_STATUS);
        n_vec++;
        if (bus !== 8'h01) begin n_err++; $display("FAIL w0_keeps: got %h want 01", bus); end
    endtask

    task automatic test_irq_enable();
        int guard;
        cyc(1, A_CTRL, 8'h01);
        guard = 0;
        while (m_count == 0 && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        cyc(1, A_STATUS, 8'h01);
        guard = 0;
        while (!m_pending && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        setup_read(A_STATUS);
        n_vec++;
        if (bus !== 8'h01 || interrupt !== 1'b0) begin n_err++; $display("FAIL masked_pend: got %h/%b want 01/0", bus, interrupt); end
        cyc(1, A_CTRL, 8'h03);
        n_vec++;
        if (interrupt !== 1'b1) begin n_err++; $display("FAIL unmask_irq: got %b want 1", interrupt); end
        guard = 0;
        while (m_count != 1 && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        cyc(1, A_STATUS, 8'h01);
        cyc(1, A_RELOAD, 8'd5);
        setup_read(A_STATUS);
        n_vec++;
        if (bus !== 8'h00) begin n_err++; $display("FAIL reload_suppress: got %h want 00", bus); end
        setup_read(A_COUNT);
        n_vec++;
        if (bus !== 8'd5) begin n_err++; $display("FAIL reload_loads: got %h want 05", bus); end
    endtask

    task automatic test_reset_midcount();
        int guard;
        cyc(1, 8'h20, 8'h77);
        cyc(1, A_OUT, 8'hFF);
        cyc(1, A_RELOAD, 8'd5);
        guard = 0;
        while (m_count != 2 && guard < 300) begin cyc(0, A_COUNT, 8'h00); guard++; end
        reset = 1'b1;
        setup_read(8'h20);
        n_vec++;
        if (bus !== 8'hzz && bus !== 8'h00) begin n_err++; $display("FAIL rst_release: got %h want zz", bus); end
        cyc(1, 8'h20, 8'h11);
        reset = 1'b0;
        n_vec++;
        if (io_out !== 8'h00 || interrupt !== 1'b0) begin n_err++; $display("FAIL rst_outs: got %h/%b want 00/0", io_out, interrupt); end
        cyc(0, A_COUNT, 8'h00);
        for (int i = 0; i < 5; i++) begin
            setup_read(8'(IO_BASE + 8'(i)));
            n_vec++;
            if (bus !== 8'h00) begin n_err++; $display("FAIL rst_reg%0d: got %h want 00", i, bus); end
        end
        setup_read(8'h20);
        n_vec++;
        if (bus !== 8'h77) begin n_err++; $display("FAIL ram_kept: got %h want 77", bus); end
    endtask

    task automatic test_random();
        logic       wr;
        logic [7:0] a, d, want;
        for (int i = 0; i < 64; i++) cyc(1, 8'(i), 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            wr = 1'($urandom % 2);
            a  = ($urandom % 2 == 0) ? 8'($urandom % 64) : 8'(IO_BASE + 8'($urandom % 16));
            d  = (a == A_RELOAD) ? 8'($urandom % 6) : 8'($urandom);
            if (!wr) begin
                setup_read(a);
                want = model_read(a);
                n_vec++;
                if (bus !== want) begin n_err++; $display("FAIL rnd_read%0d @%h: got %h want %h", i, a, bus, want); end
            end
            cyc(wr, a, d);
            n_vec++;
            if (io_out !== m_out || interrupt !== (m_pending && m_ien)) begin
                n_err++;
                $display("FAIL rnd_outs%0d: got %h/%b want %h/%b", i, io_out, interrupt, m_out, m_pending && m_ien);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ram();
        test_io_regs();
        test_timer();
        test_status_race();
        test_irq_enable();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
